// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage feeding the decoder. Holds the PC, issues
//   word-aligned requests to instruction memory, buffers in-order responses
//   in a small prefetch queue tagged with their PC, and hands {inst, inst_pc}
//   to decode. A redirect flushes the queue and discards responses still in
//   flight for the abandoned path.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready), addr = pc
//   imem_rsp_*        in-order fetch responses, latency >= 1 cycle
//   redirect_*        taken branch/jump: refetch from redirect_pc & ~3
//   inst_valid/ready  decode channel; inst/inst_pc = queue head
//
// Handshake rule (all channels): a transfer happens in a cycle where
// valid && ready are both high at the rising edge. Valid never waits for
// ready, and the payload stays stable while valid && !ready.
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Drop counter width: bounds how many abandoned fetches the memory may
    // still have in flight across a burst of redirects.
    localparam int DW = 8;
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    // live_q: requests in flight whose responses will be kept (one tag each).
    // drop_q: requests in flight whose responses will be discarded.
    // Total outstanding = live_q + drop_q; only live fetches consume credit.
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [PW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [31:0] q_data_q [FIFO_DEPTH];
    logic [31:0] q_pc_q   [FIFO_DEPTH];
    logic [31:0] tag_q    [FIFO_DEPTH];

    logic [CW:0] credit_used;
    logic        req_fire;
    logic        rsp_drop;
    logic        rsp_keep;
    logic        head_valid;
    logic        pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        credit_used    = {1'b0, live_q} + {1'b0, count_q};
        imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_W);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        // A response in a redirect cycle is never kept, whichever path it was on.
        rsp_drop   = imem_rsp_valid && (drop_q != '0);
        rsp_keep   = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

        head_valid = (count_q != '0);
        inst_valid = !reset && head_valid;
        inst       = reset ? 32'd0 : q_data_q[q_rd_q];
        inst_pc    = reset ? 32'd0 : q_pc_q[q_rd_q];
        // A decoder pop during a redirect is moot: the entry is flushed anyway.
        pop        = inst_valid && inst_ready && !redirect_valid;
    end

    always_comb begin
        pc_d     = pc_q;
        live_d   = live_q;
        count_d  = count_q;
        drop_d   = drop_q;
        q_rd_d   = q_rd_q;
        q_wr_d   = q_wr_q;
        tag_rd_d = tag_rd_q;
        tag_wr_d = tag_wr_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc & ~32'd3;
            // Every fetch still in flight after this cycle's response becomes
            // a drop, including older drops.
            drop_d   = drop_q + DW'(live_q) - DW'(imem_rsp_valid);
            live_d   = '0;
            count_d  = '0;
            q_rd_d   = '0;
            q_wr_d   = '0;
            tag_rd_d = '0;
            tag_wr_d = '0;
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + 32'd4;
                tag_wr_d = next_ptr(tag_wr_q);
            end
            if (rsp_drop) begin
                drop_d = drop_q - 1'b1;
            end
            if (rsp_keep) begin
                tag_rd_d = next_ptr(tag_rd_q);
                q_wr_d   = next_ptr(q_wr_q);
            end
            if (pop) begin
                q_rd_d = next_ptr(q_rd_q);
            end
            live_d  = live_q + CW'(req_fire) - CW'(rsp_keep);
            count_d = count_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            live_q   <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            q_rd_q   <= '0;
            q_wr_q   <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_data_q[i] <= '0;
                q_pc_q[i]   <= '0;
                tag_q[i]    <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            live_q   <= live_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            q_rd_q   <= q_rd_d;
            q_wr_q   <= q_wr_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
            if (req_fire) begin
                tag_q[tag_wr_q] <= pc_q;
            end
            // Kept response and its tag move into the queue on the same edge.
            if (rsp_keep) begin
                q_data_q[q_wr_q] <= imem_rsp_data;
                q_pc_q[q_wr_q]   <= tag_q[tag_rd_q];
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Drives inst_fetch against an in-order instruction memory model and a
//   decoder model. Expected behaviour is derived from fetch "epochs": every
//   redirect or reset starts a new epoch, and only responses to requests of
//   the current epoch may reach the decoder, in request order.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // ---- clock ----
    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    // ---- reference model state ----
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    pend_t       pend_q[$];     // memory: accepted requests awaiting response
    logic [31:0] exp_q[$];      // PCs expected at the decoder, head first
    logic [31:0] exp_req_pc;
    int          epoch;
    int          cyc;
    int          n_checks;
    int          n_fail;
    bit          rst_prev;

    int req_rdy_pct  = 100;
    int inst_rdy_pct = 100;
    int rsp_pct      = 100;
    int lat_min      = 1;
    int lat_max      = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (pend_q[i]) if (pend_q[i].epoch == epoch) n++;
        return n;
    endfunction

    function automatic bit rsp_due();
        return (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    endfunction

    // ---- scoreboard check ----
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---- driver: one clock cycle ----
    task automatic step(input bit rst, input bit redir, input logic [31:0] tgt,
                        input bit irdy, input bit qrdy);
        bit          exp_rv;
        bit          exp_iv;
        bit          fire;
        pend_t       e;
        logic [31:0] tmp;
        @(negedge clk);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = tgt;
        inst_ready     = irdy;
        imem_req_ready = qrdy;
        if (!rst && rsp_due() && ($urandom_range(99) < rsp_pct)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (rst_prev && !rst) begin
            check_eq("rst_inst", inst, 32'd0);
            check_eq("rst_inst_pc", inst_pc, 32'd0);
        end
        exp_rv = !rst && !redir && ((live_cnt() + exp_q.size()) < DEPTH);
        check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check_eq("req_addr", imem_req_addr, exp_req_pc);
        exp_iv = !rst && (exp_q.size() > 0);
        check_eq("inst_valid", 32'(inst_valid), 32'(exp_iv));
        if (exp_iv) begin
            check_eq("inst_pc", inst_pc, exp_q[0]);
            check_eq("inst", inst, mem_word(exp_q[0]));
        end

        // advance the model across the coming rising edge
        fire = imem_req_valid && qrdy;
        if (rst) begin
            pend_q.delete();
            exp_q.delete();
            exp_req_pc = RESET_PC;
            epoch++;
        end else begin
            if (exp_iv && irdy && !redir) tmp = exp_q.pop_front();
            if (imem_rsp_valid) begin
                e = pend_q.pop_front();
                if (!redir && e.epoch == epoch) exp_q.push_back(e.addr);
            end
            if (fire) begin
                e.addr  = imem_req_addr;
                e.epoch = epoch;
                e.due   = cyc + $urandom_range(lat_max, lat_min);
                pend_q.push_back(e);
            end
            if (redir) begin
                exp_q.delete();
                epoch++;
                exp_req_pc = tgt & ~32'd3;
            end else if (fire) begin
                exp_req_pc = exp_req_pc + 32'd4;
            end
        end
        rst_prev = rst;
        cyc++;
    endtask

    task automatic run_steps(input int n, input bit irdy, input bit qrdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, irdy, qrdy);
    endtask

    task automatic rand_steps(input int n, input int redir_pct);
        bit rd;
        bit ir;
        bit qr;
        for (int i = 0; i < n; i++) begin
            rd = ($urandom_range(99) < redir_pct);
            ir = ($urandom_range(99) < inst_rdy_pct);
            qr = ($urandom_range(99) < req_rdy_pct);
            step(1'b0, rd, $urandom, ir, qr);
        end
    endtask

    // ---- main sequence ----
    initial begin
        bit found;
        exp_req_pc = RESET_PC;
        epoch      = 0;
        cyc        = 0;
        n_checks   = 0;
        n_fail     = 0;
        rst_prev   = 1'b0;

        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

        // sequential fetch, 1-cycle memory, decoder always ready
        run_steps(20, 1'b1, 1'b1);

        // decoder stalls: queue fills, requests stop, head holds
        run_steps(10, 1'b0, 1'b1);
        run_steps(20, 1'b1, 1'b1);

        // redirect with two fetches in flight on a slow memory
        lat_min = 4;
        lat_max = 4;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (live_cnt() == 2) found = 1'b1;
            else step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        end
        check_eq("t3_two_outstanding", 32'(found), 32'd1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
        run_steps(20, 1'b1, 1'b1);
        lat_min = 1;
        lat_max = 1;
        run_steps(5, 1'b1, 1'b1);

        // memory not accepting requests
        run_steps(5, 1'b1, 1'b0);
        run_steps(10, 1'b1, 1'b1);

        // redirect coinciding with a response and a decoder pop
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (exp_q.size() > 0 && rsp_due()) found = 1'b1;
            else step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        end
        check_eq("t5_rsp_and_pop", 32'(found), 32'd1);
        step(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
        run_steps(15, 1'b1, 1'b1);

        // address wrap, then reset mid-stream
        step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1);
        run_steps(12, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        run_steps(10, 1'b1, 1'b1);

        // randomized traffic
        for (int r = 0; r < 8; r++) begin
            req_rdy_pct  = $urandom_range(100, 40);
            inst_rdy_pct = $urandom_range(100, 30);
            rsp_pct      = $urandom_range(100, 50);
            lat_min      = $urandom_range(2, 1);
            lat_max      = lat_min + $urandom_range(3, 0);
            rand_steps(250, 5);
            if ($urandom_range(3) == 0) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
